frog_matrix_scan: RTL and testbench

Consumer end of the frog position interface. Takes the 4-bit frog column/row produced by the frog position tracker and drives a 16x16 row-scanned LED matrix. Rows are time-multiplexed one at a time, with a blanking gap between rows to prevent ghosting. Each row shows a background bitmap fetched from a row-addressed source, with the frog pixel overlaid and optionally blinking.

---
 rtl/frog_pkg.sv | 24 ++
 rtl/scan_timer.sv | 37 +++
 rtl/frog_matrix_scan.sv | 150 +++++++++++++++
 tb/tb_frog_matrix_scan.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// frog_pkg
// Shared definitions for the frog display path: grid size, coordinate type,
// scan FSM states and the frog start position (also used by the position
// tracker's reset so both ends agree on where the frog starts).
package frog_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;

    typedef logic [3:0] coord_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam coord_t FROG_START_COL = 4'd7;
    localparam coord_t FROG_START_ROW = 4'd0;

    function automatic logic [GRID_W-1:0] onehot_of(input coord_t idx);
        return GRID_W'(1) << idx;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer
// Terminal-count counter. Counts 0..i_term while i_en is high, pulses o_done
// on the terminal count and wraps to 0 on that same edge.
// Ports:
//   clock   system clock
//   reset   async active-low reset, count -> 0
//   i_en    advance the count this cycle
//   i_term  terminal count (last value before wrap)
//   o_cnt   current count
//   o_done  high while i_en and count == i_term
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    assign o_done = i_en && (r_cnt == i_term);
    assign o_cnt  = r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (o_done) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frog_matrix_scan.sv
// frog_matrix_scan
// Row-scanned 16x16 LED matrix driver. Each row is blanked, then driven with
// its background bitmap OR'd with the (optionally blinking) frog pixel.
// Ports:
//   clock        system clock
//   reset        async active-low reset
//   frog_col/row frog position from the tracker, sampled once per frame
//   bg_addr      background row address (current scan row)
//   bg_data      background pixels, valid one cycle after bg_addr
//   row_sel      one-hot row enable, zero while blanking
//   col_data     column pixels of the driven row
//   frame_start  one-cycle pulse at the start of each frame
//
// state | meaning
// BLANK | all rows off, bg_addr settles, pixels latched on last count
// DRIVE | one row on with latched pixels for DWELL_CYCLES
module frog_matrix_scan
    import frog_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        frog_col,
    input  logic [3:0]        frog_row,
    output logic [3:0]        bg_addr,
    input  logic [GRID_W-1:0] bg_data,
    output logic [GRID_H-1:0] row_sel,
    output logic [GRID_W-1:0] col_data,
    output logic              frame_start
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int FTRM = (BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0;

    scan_state_t       r_state;
    coord_t            r_row_idx;
    logic [GRID_H-1:0] r_row_sel;
    logic [GRID_W-1:0] r_col_data;
    coord_t            r_lat_col;
    coord_t            r_lat_row;
    logic              r_vis;
    logic              r_lat_vis;

    scan_state_t       w_state_nxt;
    coord_t            w_row_nxt;
    logic [GRID_H-1:0] w_row_sel_nxt;
    logic [GRID_W-1:0] w_col_nxt;
    logic [GRID_W-1:0] w_frog_mask;
    logic [CW-1:0]     w_phase_term;
    logic [CW-1:0]     w_phase_cnt;
    logic              w_phase_done;
    logic              w_frame_start;
    logic              w_blink_done;
    logic [FW-1:0]     w_frame_cnt_unused;

    assign w_phase_term = (r_state == BLANK) ? CW'(BLANK_CYCLES - 1) : CW'(DWELL_CYCLES - 1);

    scan_timer #(.W(CW)) u_phase_timer (
        .clock  (clock),
        .reset  (reset),
        .i_en   (1'b1),
        .i_term (w_phase_term),
        .o_cnt  (w_phase_cnt),
        .o_done (w_phase_done)
    );

    assign w_frame_start = (r_state == BLANK) && (r_row_idx == 4'd0) && (w_phase_cnt == '0);

    scan_timer #(.W(FW)) u_frame_timer (
        .clock  (clock),
        .reset  (reset),
        .i_en   (w_frame_start && (BLINK_FRAMES != 0)),
        .i_term (FW'(FTRM)),
        .o_cnt  (w_frame_cnt_unused),
        .o_done (w_blink_done)
    );

    assign w_frog_mask = (r_lat_vis && (r_row_idx == r_lat_row)) ? onehot_of(r_lat_col) : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row_idx;
        w_row_sel_nxt = r_row_sel;
        w_col_nxt     = r_col_data;
        case (r_state)
            BLANK: begin
                if (w_phase_done) begin
                    w_state_nxt   = DRIVE;
                    w_row_sel_nxt = onehot_of(r_row_idx);
                    w_col_nxt     = bg_data | w_frog_mask;
                end
            end
            DRIVE: begin
                if (w_phase_done) begin
                    w_state_nxt   = BLANK;
                    w_row_nxt     = r_row_idx + 4'd1;
                    w_row_sel_nxt = '0;
                    w_col_nxt     = '0;
                end
            end
            default: w_state_nxt = BLANK;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= BLANK;
            r_row_idx  <= '0;
            r_row_sel  <= '0;
            r_col_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_row_idx  <= w_row_nxt;
            r_row_sel  <= w_row_sel_nxt;
            r_col_data <= w_col_nxt;
        end
    end

    // Position and visibility are frozen per frame so a move or a blink
    // toggle never tears the image. Visibility takes the pre-toggle value,
    // so a toggle shows up from the following frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lat_col <= FROG_START_COL;
            r_lat_row <= FROG_START_ROW;
            r_vis     <= 1'b1;
            r_lat_vis <= 1'b1;
        end else begin
            if (w_frame_start) begin
                r_lat_col <= frog_col;
                r_lat_row <= frog_row;
                r_lat_vis <= r_vis;
            end
            if (w_blink_done) begin
                r_vis <= ~r_vis;
            end
        end
    end

    assign bg_addr     = r_row_idx;
    assign row_sel     = r_row_sel;
    assign col_data    = r_col_data;
    assign frame_start = w_frame_start;

endmodule

// File: tb/tb_frog_matrix_scan.sv
module tb_frog_matrix_scan;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  fc_a = 4'd7, fr_a = 4'd0, fc_b = 4'd5, fr_b = 4'd9;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] bg_a, bg_b, sel_a, col_a, sel_b, col_b;
    logic        fs_a, fs_b;
    logic [15:0] bg_mem [16];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          c;
        logic [15:0] sel;
        logic [15:0] col;
        logic        fs;
        logic [3:0]  addr;
    } vec_t;

    vec_t vecs[$];

    frog_matrix_scan #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .BLINK_FRAMES(0)) dut_a (
        .clock(clock), .reset(reset), .frog_col(fc_a), .frog_row(fr_a),
        .bg_addr(addr_a), .bg_data(bg_a), .row_sel(sel_a), .col_data(col_a),
        .frame_start(fs_a)
    );

    frog_matrix_scan #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) dut_b (
        .clock(clock), .reset(reset), .frog_col(fc_b), .frog_row(fr_b),
        .bg_addr(addr_b), .bg_data(bg_b), .row_sel(sel_b), .col_data(col_b),
        .frame_start(fs_b)
    );

    always #5 clock = ~clock;

    // Background source: registered lookup, one cycle behind the address.
    always @(posedge clock) begin
        bg_a <= bg_mem[addr_a];
        bg_b <= bg_mem[addr_b];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_inv();
        chk("onehot_a", {15'd0, $onehot0(sel_a)}, 16'd1);
        chk("onehot_b", {15'd0, $onehot0(sel_b)}, 16'd1);
        chk("dark_a", (sel_a == 16'd0) ? col_a : 16'd0, 16'd0);
        chk("dark_b", (sel_b == 16'd0) ? col_b : 16'd0, 16'd0);
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            check_inv();
        end
    endtask

    task automatic restart();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        cyc = 0;
        @(negedge clock);
        check_inv();
    endtask

    initial begin
        bit moved;
        for (int i = 0; i < 16; i++) bg_mem[i] = 16'h0000;

        // cycle, row_sel, col_data, frame_start, bg_addr
        vecs.push_back('{0,   16'h0000, 16'h0000, 1'b1, 4'd0});
        vecs.push_back('{1,   16'h0000, 16'h0000, 1'b0, 4'd0});
        vecs.push_back('{2,   16'h0001, 16'h0080, 1'b0, 4'd0});
        vecs.push_back('{5,   16'h0001, 16'h0080, 1'b0, 4'd0});
        vecs.push_back('{6,   16'h0000, 16'h0000, 1'b0, 4'd1});
        vecs.push_back('{7,   16'h0000, 16'h0000, 1'b0, 4'd1});
        vecs.push_back('{8,   16'h0002, 16'h0000, 1'b0, 4'd1});
        vecs.push_back('{11,  16'h0002, 16'h0000, 1'b0, 4'd1});
        vecs.push_back('{38,  16'h0040, 16'h0000, 1'b0, 4'd6});
        vecs.push_back('{95,  16'h8000, 16'h0000, 1'b0, 4'd15});
        vecs.push_back('{96,  16'h0000, 16'h0000, 1'b1, 4'd0});
        vecs.push_back('{97,  16'h0000, 16'h0000, 1'b0, 4'd0});
        vecs.push_back('{98,  16'h0001, 16'h0100, 1'b0, 4'd0});
        vecs.push_back('{101, 16'h0001, 16'h0100, 1'b0, 4'd0});
        vecs.push_back('{102, 16'h0000, 16'h0000, 1'b0, 4'd1});

        // Basic scan, frog (7,0); frog column moves to 8 mid-frame at cycle 40.
        restart();
        moved = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (!moved && vecs[i].c >= 40) begin
                step_to(40);
                fc_a  = 4'd8;
                moved = 1'b1;
            end
            step_to(vecs[i].c);
            chk("row_sel", sel_a, vecs[i].sel);
            chk("col_data", col_a, vecs[i].col);
            chk("frame_start", {15'd0, fs_a}, {15'd0, vecs[i].fs});
            chk("bg_addr", {12'd0, addr_a}, {12'd0, vecs[i].addr});
        end

        // Blink with BLINK_FRAMES=2, frog (5,9): row 9 drives at 96f+56..59.
        fc_a = 4'd7; fr_a = 4'd0;
        restart();
        for (int f = 0; f < 6; f++) begin
            step_to(96 * f + 57);
            chk("blink_sel", sel_b, 16'h0200);
            chk("blink_col", col_b, (f == 2 || f == 3) ? 16'h0000 : 16'h0020);
        end

        // Background fetch with frog on row 3.
        bg_mem[3] = 16'hA5A5;
        fc_a = 4'd0; fr_a = 4'd3;
        restart();
        step_to(20);
        chk("bg_sel", sel_a, 16'h0008);
        chk("bg_col_f0", col_a, 16'hA5A5);
        chk("bg_col_b", col_b, 16'hA5A5);
        step_to(23);
        chk("bg_col_f0_end", col_a, 16'hA5A5);
        step_to(26);
        chk("bg_row4", col_a, 16'h0000);
        step_to(30);
        fc_a = 4'd1;
        step_to(116);
        chk("bg_col_f1", col_a, 16'hA5A7);
        bg_mem[3] = 16'h0000;

        // Reset during DRIVE of row 6 in frame 2 (dut_b frog hidden there).
        bg_mem[6] = 16'h3C00;
        fc_a = 4'd7; fr_a = 4'd0;
        fc_b = 4'd7; fr_b = 4'd0;
        restart();
        step_to(194);
        chk("hidden_sel_b", sel_b, 16'h0001);
        chk("hidden_col_b", col_b, 16'h0000);
        step_to(230);
        chk("pre_rst_sel", sel_a, 16'h0040);
        chk("pre_rst_col", col_a, 16'h3C00);
        reset = 1'b0;
        #1;
        chk("rst_sel_a", sel_a, 16'h0000);
        chk("rst_col_a", col_a, 16'h0000);
        chk("rst_sel_b", sel_b, 16'h0000);
        chk("rst_col_b", col_b, 16'h0000);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        cyc = 0;
        @(negedge clock);
        check_inv();
        chk("rst_fs", {15'd0, fs_a}, 16'd1);
        chk("rst_addr", {12'd0, addr_a}, 16'd0);
        step_to(2);
        chk("rst_row0_sel", sel_a, 16'h0001);
        chk("rst_row0_col", col_a, 16'h0080);
        chk("rst_vis_b", col_b, 16'h0080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
